// File: rtl/time_gen_pkg.sv
// Shared widths, terminal values and the set-value range check for the wall-clock generator.
package time_gen_pkg;

   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HR_W  = 5;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   // True when a requested hh:mm lies inside the clock's range.
   function automatic logic set_in_range(input logic [HR_W-1:0]  hh,
                                         input logic [MIN_W-1:0] mm,
                                         input logic [HR_W-1:0]  hr_max);
      return (hh <= hr_max) && (mm <= MIN_MAX);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_HZ; tick is high during the last count while enabled.
module tick_prescaler #(
   parameter int CLK_HZ = 256
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int              PC_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PC_W-1:0] PC_MAX = PC_W'(CLK_HZ - 1);

   logic [PC_W-1:0] r_pcnt;

   // Prescaler count: clear on load, otherwise advance and wrap at PC_MAX while enabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcnt <= '0;
      end else if (clr) begin
         r_pcnt <= '0;
      end else if (en) begin
         if (r_pcnt == PC_MAX) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + PC_W'(1);
         end
      end else begin
         r_pcnt <= r_pcnt;
      end
   end

   assign tick = en && (r_pcnt == PC_MAX);

endmodule

// File: rtl/wall_time_gen.sv
// Wall-clock time generator: 1 Hz prescaler plus ss/mm/hh cascade with load, run and fast mode.
module wall_time_gen
   import time_gen_pkg::*;
#(
   parameter int CLK_HZ = 256,
   parameter int HOURS  = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             fast_mode,
   input  logic             set_en,
   input  logic [HR_W-1:0]  set_hh,
   input  logic [MIN_W-1:0] set_mm,
   output logic             one_second,
   output logic             one_minute,
   output logic             one_hour,
   output logic             day_wrap,
   output logic             set_err,
   output logic [SEC_W-1:0] ss,
   output logic [MIN_W-1:0] mm,
   output logic [HR_W-1:0]  hh
);

   localparam logic [HR_W-1:0] HR_MAX = HR_W'(HOURS - 1);

   logic             w_tick;
   logic             w_load;
   logic [SEC_W-1:0] w_ss_n;
   logic [MIN_W-1:0] w_mm_n;
   logic [HR_W-1:0]  w_hh_n;
   logic             w_sec_p, w_min_p, w_hr_p, w_day_p, w_err_p;

   logic [SEC_W-1:0] r_ss;
   logic [MIN_W-1:0] r_mm;
   logic [HR_W-1:0]  r_hh;
   logic             r_sec_p, r_min_p, r_hr_p, r_day_p, r_err_p;

   // A valid load clears the prescaler so the next second is a full period away.
   assign w_load = set_en && set_in_range(set_hh, set_mm, HR_MAX);

   tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (run),
      .clr     (w_load),
      .tick    (w_tick)
   );

   // Next time value and pulses: a valid load beats a coincident tick.
   always_comb begin
      w_ss_n  = r_ss;
      w_mm_n  = r_mm;
      w_hh_n  = r_hh;
      w_sec_p = 1'b0;
      w_min_p = 1'b0;
      w_hr_p  = 1'b0;
      w_day_p = 1'b0;
      w_err_p = set_en && !w_load;
      if (w_load) begin
         w_ss_n = '0;
         w_mm_n = set_mm;
         w_hh_n = set_hh;
      end else if (w_tick) begin
         w_sec_p = 1'b1;
         if (fast_mode || (r_ss == SEC_MAX)) begin
            w_ss_n  = '0;
            w_min_p = 1'b1;
         end else begin
            w_ss_n = r_ss + SEC_W'(1);
         end
         if (w_min_p) begin
            if (r_mm == MIN_MAX) begin
               w_mm_n = '0;
               w_hr_p = 1'b1;
               if (r_hh == HR_MAX) begin
                  w_hh_n  = '0;
                  w_day_p = 1'b1;
               end else begin
                  w_hh_n = r_hh + HR_W'(1);
               end
            end else begin
               w_mm_n = r_mm + MIN_W'(1);
            end
         end else begin
            w_mm_n = r_mm;
         end
      end else begin
         w_ss_n = r_ss;
      end
   end

   // Registered time counters and one-cycle pulse outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ss    <= '0;
         r_mm    <= '0;
         r_hh    <= '0;
         r_sec_p <= 1'b0;
         r_min_p <= 1'b0;
         r_hr_p  <= 1'b0;
         r_day_p <= 1'b0;
         r_err_p <= 1'b0;
      end else begin
         r_ss    <= w_ss_n;
         r_mm    <= w_mm_n;
         r_hh    <= w_hh_n;
         r_sec_p <= w_sec_p;
         r_min_p <= w_min_p;
         r_hr_p  <= w_hr_p;
         r_day_p <= w_day_p;
         r_err_p <= w_err_p;
      end
   end

   assign ss         = r_ss;
   assign mm         = r_mm;
   assign hh         = r_hh;
   assign one_second = r_sec_p;
   assign one_minute = r_min_p;
   assign one_hour   = r_hr_p;
   assign day_wrap   = r_day_p;
   assign set_err    = r_err_p;

endmodule

// File: tb/tb_wall_time_gen.sv
// Directed bench: CLK_HZ=4 with a 24-hour and a 12-hour instance.
module tb_wall_time_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, run, fast_mode, set_en;
   logic [4:0] set_hh;
   logic [5:0] set_mm;
   logic       one_second, one_minute, one_hour, day_wrap, set_err;
   logic [5:0] ss, mm;
   logic [4:0] hh;

   logic       rst12_n, run12, set_en12;
   logic [4:0] set_hh12;
   logic [5:0] set_mm12;
   logic       sec12, min12, hr12, day12, err12;
   logic [5:0] ss12, mm12;
   logic [4:0] hh12;

   wall_time_gen #(.CLK_HZ(4), .HOURS(24)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .fast_mode(fast_mode),
      .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm),
      .one_second(one_second), .one_minute(one_minute), .one_hour(one_hour),
      .day_wrap(day_wrap), .set_err(set_err), .ss(ss), .mm(mm), .hh(hh)
   );

   wall_time_gen #(.CLK_HZ(4), .HOURS(12)) dut12 (
      .clk(clk), .reset_n(rst12_n), .run(run12), .fast_mode(1'b0),
      .set_en(set_en12), .set_hh(set_hh12), .set_mm(set_mm12),
      .one_second(sec12), .one_minute(min12), .one_hour(hr12),
      .day_wrap(day12), .set_err(err12), .ss(ss12), .mm(mm12), .hh(hh12)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_sec = 0, n_min = 0, n_hr = 0, n_day = 0, n_err = 0, n_tri = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse monitor: outputs are sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (one_second) n_sec++;
      if (one_minute) n_min++;
      if (one_hour)   n_hr++;
      if (day_wrap)   n_day++;
      if (set_err)    n_err++;
      if (one_minute && one_hour && day_wrap) n_tri++;
   end

   typedef struct {
      string      name;
      logic       run;
      logic       fast;
      logic       set;
      logic [4:0] shh;
      logic [5:0] smm;
      int         cyc;
      int         ess, emm, ehh;
      int         nsec, nmin, nhr, nday, nerr, ntri;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   // Called right after reset release at a falling edge.
   task automatic check_first_pulse(input string tag);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_no_early_pulse"}, int'(one_second), 0);
      end
      @(negedge clk);
      chk({tag, "_first_pulse"}, int'(one_second), 1);
      chk({tag, "_first_ss"}, int'(ss), 1);
   endtask

   initial begin
      int s_sec, s_min, s_hr, s_day, s_err, s_tri;

      //          name         run  fast set  shh    smm   cyc  ss mm hh sec min hr day err tri
      vec[0]  = '{"minute",    1'b1,1'b0,1'b0,5'd0,  6'd0, 236, 0, 1, 0, 59, 1, 0, 0, 0, 0};
      vec[1]  = '{"load2359",  1'b1,1'b0,1'b1,5'd23, 6'd59,  1, 0,59,23,  0, 0, 0, 0, 0, 0};
      vec[2]  = '{"daywrap",   1'b1,1'b0,1'b0,5'd0,  6'd0, 240, 0, 0, 0, 60, 1, 1, 1, 0, 1};
      vec[3]  = '{"fast59",    1'b1,1'b1,1'b0,5'd0,  6'd0, 236, 0,59, 0, 59,59, 0, 0, 0, 0};
      vec[4]  = '{"fasthour",  1'b1,1'b1,1'b0,5'd0,  6'd0,   4, 0, 0, 1,  1, 1, 1, 0, 0, 0};
      vec[5]  = '{"bad_hh",    1'b0,1'b0,1'b1,5'd24, 6'd0,   1, 0, 0, 1,  0, 0, 0, 0, 1, 0};
      vec[6]  = '{"bad_mm",    1'b0,1'b0,1'b1,5'd5,  6'd60,  1, 0, 0, 1,  0, 0, 0, 0, 1, 0};
      vec[7]  = '{"to_pcnt2",  1'b1,1'b0,1'b0,5'd0,  6'd0,   2, 0, 0, 1,  0, 0, 0, 0, 0, 0};
      vec[8]  = '{"frozen",    1'b0,1'b0,1'b0,5'd0,  6'd0,  10, 0, 0, 1,  0, 0, 0, 0, 0, 0};
      vec[9]  = '{"resume3",   1'b1,1'b0,1'b0,5'd0,  6'd0,   1, 0, 0, 1,  0, 0, 0, 0, 0, 0};
      vec[10] = '{"resume_tk", 1'b1,1'b0,1'b0,5'd0,  6'd0,   1, 1, 0, 1,  1, 0, 0, 0, 0, 0};
      vec[11] = '{"pre_tick",  1'b1,1'b0,1'b0,5'd0,  6'd0,   3, 1, 0, 1,  0, 0, 0, 0, 0, 0};
      vec[12] = '{"load_tick", 1'b1,1'b0,1'b1,5'd12, 6'd34,  1, 0,34,12,  0, 0, 0, 0, 0, 0};
      vec[13] = '{"post_load", 1'b1,1'b0,1'b0,5'd0,  6'd0,   4, 1,34,12,  1, 0, 0, 0, 0, 0};
      vec[14] = '{"to_123456", 1'b1,1'b0,1'b0,5'd0,  6'd0, 220,56,34,12, 55, 0, 0, 0, 0, 0};

      reset_n = 1'b0; run = 1'b1; fast_mode = 1'b0; set_en = 1'b0;
      set_hh = 5'd0; set_mm = 6'd0;
      rst12_n = 1'b0; run12 = 1'b0; set_en12 = 1'b0; set_hh12 = 5'd0; set_mm12 = 6'd0;
      repeat (3) @(negedge clk);
      chk("rst_ss", int'(ss), 0);
      chk("rst_mm", int'(mm), 0);
      chk("rst_hh", int'(hh), 0);
      chk("rst_pulses", int'({one_second, one_minute, one_hour, day_wrap, set_err}), 0);
      reset_n = 1'b1;
      rst12_n = 1'b1;
      check_first_pulse("boot");

      for (int i = 0; i < NV; i++) begin
         s_sec = n_sec; s_min = n_min; s_hr = n_hr;
         s_day = n_day; s_err = n_err; s_tri = n_tri;
         run = vec[i].run; fast_mode = vec[i].fast;
         set_hh = vec[i].shh; set_mm = vec[i].smm; set_en = vec[i].set;
         @(negedge clk);
         set_en = 1'b0;
         repeat (vec[i].cyc - 1) @(negedge clk);
         chk({vec[i].name, "_ss"},   int'(ss), vec[i].ess);
         chk({vec[i].name, "_mm"},   int'(mm), vec[i].emm);
         chk({vec[i].name, "_hh"},   int'(hh), vec[i].ehh);
         chk({vec[i].name, "_nsec"}, n_sec - s_sec, vec[i].nsec);
         chk({vec[i].name, "_nmin"}, n_min - s_min, vec[i].nmin);
         chk({vec[i].name, "_nhr"},  n_hr - s_hr,   vec[i].nhr);
         chk({vec[i].name, "_nday"}, n_day - s_day, vec[i].nday);
         chk({vec[i].name, "_nerr"}, n_err - s_err, vec[i].nerr);
         chk({vec[i].name, "_ntri"}, n_tri - s_tri, vec[i].ntri);
      end

      // Asynchronous reset between clock edges at 12:34:56.
      #2 reset_n = 1'b0;
      #1;
      chk("async_ss", int'(ss), 0);
      chk("async_mm", int'(mm), 0);
      chk("async_hh", int'(hh), 0);
      chk("async_pulses", int'({one_second, one_minute, one_hour, day_wrap, set_err}), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check_first_pulse("rerun");

      // 12-hour instance: 11:59:59 + 1 s wraps to 00:00:00 with day_wrap.
      set_hh12 = 5'd11; set_mm12 = 6'd59; set_en12 = 1'b1;
      @(negedge clk);
      set_en12 = 1'b0;
      chk("h12_load_hh", int'(hh12), 11);
      chk("h12_load_mm", int'(mm12), 59);
      run12 = 1'b1;
      repeat (236) @(negedge clk);
      chk("h12_ss59", int'(ss12), 59);
      repeat (3) @(negedge clk);
      chk("h12_no_early_wrap", int'(day12), 0);
      @(negedge clk);
      chk("h12_day_wrap", int'(day12), 1);
      chk("h12_hour", int'(hr12), 1);
      chk("h12_minute", int'(min12), 1);
      chk("h12_second", int'(sec12), 1);
      chk("h12_hh", int'(hh12), 0);
      chk("h12_time", int'({mm12, ss12}), 0);
      run12 = 1'b0;
      set_hh12 = 5'd12; set_mm12 = 6'd0; set_en12 = 1'b1;
      @(negedge clk);
      set_en12 = 1'b0;
      chk("h12_set_err", int'(err12), 1);
      chk("h12_hh_kept", int'(hh12), 0);
      @(negedge clk);
      chk("h12_err_one_cycle", int'(err12), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
